fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO (w_en/r_en/data_in/data_out/empty/full interface).
- Drives the FIFO's r_en and absorbs its one-cycle registered read latency.
- Presents popped words as a valid/ready stream to a downstream consumer at full throughput (one word per clock).
- Keeps a running count of delivered words for debug and bench checking.

Parameters:
- DATA_W, 16, width of the FIFO data word and of the stream data.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_W  FIFO data_out; valid the cycle after an accepted r_en.
- fifo_r_en  output  DATA_W→1  FIFO read enable (1 bit).
- m_valid  output  1  stream word available.
- m_data  output  DATA_W  stream word.
- m_ready  input  1  downstream accepts m_data when m_valid && m_ready.
- word_count  output  CNT_W  number of stream handshakes completed since reset.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - m_valid=0, m_data=0, word_count=0, fifo_r_en=0.
  - Internal buffer count=0, in-flight=0.
  - fifo_r_en is forced 0 while rst=1.
- FIFO read contract:
  - A read issued at edge N (fifo_r_en=1 and fifo_empty=0 sampled at N) yields fifo_rd_data valid after edge N, captured at edge N+1.
  - The block never asserts fifo_r_en while fifo_empty=1; no underflow.
- Internal state:
  - 2-entry output buffer (head/tail), occupancy count 0..2.
  - 1-bit in_flight flag, set when a read was issued in the previous cycle.
- fifo_r_en is combinational: !rst && !fifo_empty && (count + in_flight − pop) < 2, where pop = m_valid && m_ready.
  - This creates a combinational path from m_ready to fifo_r_en, and it is intended.
- Capture: when in_flight=1, fifo_rd_data is written into the buffer at the clock edge.
  - A simultaneous pop and capture leaves count unchanged.
- Output:
  - m_valid = (count != 0).
  - m_data = buffer head, registered, with no combinational path from fifo_rd_data.
  - m_data holds stable while m_valid=1 and m_ready=0.
- Latency: FIFO non-empty with output buffer idle gives fifo_r_en the same cycle and m_valid two edges later.
- Throughput:
  - Steady state with m_ready=1 and FIFO non-empty gives one word per clock (count=1, in_flight=1).
  - With m_ready=0, reads stop once count + in_flight = 2.
  - The buffer never overflows.
- Ordering: words leave in exactly FIFO pop order; no drop, no duplication.
- word_count increments by 1 on each handshake and wraps modulo 2^CNT_W.
- Boundaries:
  - FIFO goes empty while a read is in flight: the in-flight word is still captured, and no further r_en is issued.
  - m_ready deasserts while a read is in flight: the word goes to buffer entry 2, and fifo_r_en=0 next cycle.
  - rst asserted mid-stream: buffered and in-flight words are discarded and all outputs return to reset values immediately.
    - The FIFO is reset by the same rst.

Decomposition:
- Shared package fifo_pkg:
  - DATA_W default (16), shared with the FIFO.
  - Read-latency constant FIFO_RD_LAT=1.
  - The block supports only FIFO_RD_LAT=1; this is checked at elaboration.
- One natural sub-module: skid_buf2, the 2-entry registered buffer with push/pop/count.
  - The top level holds the in_flight flag, r_en logic and counter.

Test Plan:
- Reset with FIFO empty, then idle for 10 cycles → fifo_r_en=0, m_valid=0, m_data=0, word_count=0 throughout.
- Write 32, 12, 5 into the FIFO, m_ready=1 → m_data sequence 32, 12, 5 on consecutive cycles.
  - First m_valid appears 2 edges after fifo_empty falls.
  - word_count ends at 3; fifo_r_en is never high while empty=1.
- Fill 8 words, m_ready=0 → exactly 2 reads issued, m_valid=1, m_data=first word held stable.
  - Release m_ready: all 8 words are delivered in order, back-to-back.
- Toggle m_ready 1/0 every cycle with 16 words 0..15 queued → output is 0..15 in order, no loss or duplication, word_count=16.
- Assert rst for one cycle with m_valid=1 and in_flight=1 → m_valid, m_data and word_count go to 0 asynchronously.
  - No stale word is presented after reset release.
- Preload word_count near wrap (CNT_W=4 build), deliver 18 words → word_count reads 2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO and its stream reader.
//   FIFO_DATA_W  : default FIFO / stream word width
//   RDR_CNT_W    : default width of the reader's delivered-word counter
//   FIFO_RD_LAT  : FIFO read latency in cycles (registered data_out)
//   BUF_DEPTH    : reader output buffer depth in words
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 16;
  localparam int unsigned RDR_CNT_W   = 16;
  localparam int unsigned FIFO_RD_LAT = 1;
  localparam int unsigned BUF_DEPTH   = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read-side signals and the outgoing valid/ready stream.
//   master : the reader (drives fifo_r_en, m_valid, m_data, word_count)
//   slave  : FIFO + downstream consumer (drive fifo_empty, fifo_rd_data, m_ready)
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_W = fifo_pkg::FIFO_DATA_W,
  parameter int unsigned CNT_W  = fifo_pkg::RDR_CNT_W
);

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_r_en;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [CNT_W-1:0]  word_count;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_r_en, m_valid, m_data, word_count
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_r_en, m_valid, m_data, word_count
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry registered output buffer (head/tail) with push/pop and occupancy.
//   clk, rst     : clock, async active-high reset
//   i_push       : write i_push_data this edge
//   i_push_data  : word to store
//   i_pop        : consume the head word this edge
//   o_count      : occupancy 0..2
//   o_valid      : head word present
//   o_head_data  : head word (registered)
module skid_buf2 #(
  parameter int unsigned DATA_W = fifo_pkg::FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head_data
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_count;

  logic [DATA_W-1:0] w_head_nxt;
  logic [DATA_W-1:0] w_tail_nxt;
  logic [1:0]        w_count_nxt;

  // Next-state for head/tail/count; a pop is only ever requested while count != 0
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    unique case ({i_push, i_pop})
      2'b10: begin
        if (r_count == 2'd0) w_head_nxt = i_push_data;
        else                 w_tail_nxt = i_push_data;
        if (r_count != 2'd2) w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        if (r_count == 2'd2) w_head_nxt = r_tail;
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        // Simultaneous pop and push: occupancy unchanged, incoming word joins behind
        if (r_count == 2'd2) begin
          w_head_nxt = r_tail;
          w_tail_nxt = i_push_data;
        end else begin
          w_head_nxt = i_push_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_count     = r_count;
  assign o_valid     = (r_count != 2'd0);
  assign o_head_data = r_head;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues r_en, absorbs the one-cycle
// read latency and presents words as a full-throughput valid/ready stream.
//   clk, rst          : clock, async active-high reset (also resets the FIFO)
//   bus.fifo_empty    : FIFO empty flag
//   bus.fifo_rd_data  : FIFO data_out, valid the cycle after an accepted r_en
//   bus.fifo_r_en     : FIFO read enable (combinational, depends on m_ready)
//   bus.m_valid/m_data/m_ready : outgoing stream
//   bus.word_count    : stream handshakes since reset, wraps
module fifo_stream_reader #(
  parameter int unsigned DATA_W = fifo_pkg::FIFO_DATA_W,
  parameter int unsigned CNT_W  = fifo_pkg::RDR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  import fifo_pkg::*;

  // The in-flight tracking below assumes exactly one cycle of read latency
  if (FIFO_RD_LAT != 1) begin : g_rd_lat_chk
    $error("fifo_stream_reader supports only FIFO_RD_LAT == 1");
  end

  logic              r_in_flight;
  logic [CNT_W-1:0]  r_word_count;

  logic              w_pop;
  logic              w_r_en;
  logic              w_valid;
  logic [1:0]        w_count;
  logic [DATA_W-1:0] w_head;
  logic [2:0]        w_occ_after_pop;

  assign w_pop = w_valid && bus.m_ready;

  // Slots committed after this edge: buffered + arriving - leaving
  assign w_occ_after_pop = 3'(w_count) + 3'(r_in_flight) - 3'(w_pop);

  // Never read while empty; stop once every buffer slot is spoken for
  assign w_r_en = !rst && !bus.fifo_empty && (w_occ_after_pop < 3'(BUF_DEPTH));

  // A read accepted at this edge returns data to be captured at the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_flight <= 1'b0;
    else     r_in_flight <= w_r_en;
  end

  // Delivered-word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_word_count <= '0;
    else if (w_pop) r_word_count <= r_word_count + CNT_W'(1);
  end

  skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_in_flight),
    .i_push_data (bus.fifo_rd_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_valid     (w_valid),
    .o_head_data (w_head)
  );

  assign bus.fifo_r_en  = w_r_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO feeds the reader,
// a 16-bit-counter instance carries the stream and a 4-bit-counter instance
// shadows the same inputs to exercise counter wrap.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_W(16), .CNT_W(16)) ifm ();
  fifo_stream_reader_if #(.DATA_W(16), .CNT_W(4))  if4 ();

  fifo_stream_reader #(.DATA_W(16), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifm)
  );

  fifo_stream_reader #(.DATA_W(16), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  // Behavioural synchronous FIFO, depth 32, registered data_out
  logic        w_en;
  logic [15:0] w_data;
  logic [15:0] f_mem [0:31];
  logic [5:0]  f_cnt;
  logic [4:0]  f_wp, f_rp;
  logic [15:0] f_rd_data;
  logic        f_do_wr, f_do_rd;

  assign f_do_wr = w_en && (f_cnt != 6'd32);
  assign f_do_rd = ifm.fifo_r_en && (f_cnt != 6'd0);

  always @(posedge clk) if (f_do_wr) f_mem[f_wp] <= w_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_cnt     <= 6'd0;
      f_wp      <= 5'd0;
      f_rp      <= 5'd0;
      f_rd_data <= 16'd0;
    end else begin
      if (f_do_wr) f_wp <= f_wp + 5'd1;
      if (f_do_rd) begin
        f_rd_data <= f_mem[f_rp];
        f_rp      <= f_rp + 5'd1;
      end
      f_cnt <= f_cnt + 6'(f_do_wr) - 6'(f_do_rd);
    end
  end

  assign ifm.fifo_empty   = (f_cnt == 6'd0);
  assign ifm.fifo_rd_data = f_rd_data;
  assign if4.fifo_empty   = ifm.fifo_empty;
  assign if4.fifo_rd_data = ifm.fifo_rd_data;
  assign if4.m_ready      = ifm.m_ready;

  // Stream / read monitor sampled on the falling edge
  logic [15:0] hs_q [$];
  int rd_issued = 0;
  int rd_viol   = 0;

  always @(negedge clk) begin
    if (!rst && ifm.m_valid && ifm.m_ready) hs_q.push_back(ifm.m_data);
    if (ifm.fifo_r_en && !ifm.fifo_empty) rd_issued <= rd_issued + 1;
    if (ifm.fifo_r_en &&  ifm.fifo_empty) rd_viol   <= rd_viol + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int base;
    logic [31:0] obs;

    rst         = 1'b1;
    w_en        = 1'b0;
    w_data      = 16'd0;
    ifm.m_ready = 1'b0;
    #1;
    check("rst_r_en",   32'(ifm.fifo_r_en),  32'd0);
    check("rst_valid",  32'(ifm.m_valid),    32'd0);
    check("rst_data",   32'(ifm.m_data),     32'd0);
    check("rst_wcount", 32'(ifm.word_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Idle with empty FIFO
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_r_en",   32'(ifm.fifo_r_en),  32'd0);
      check("idle_valid",  32'(ifm.m_valid),    32'd0);
      check("idle_data",   32'(ifm.m_data),     32'd0);
      check("idle_wcount", 32'(ifm.word_count), 32'd0);
    end

    // A: three words, consumer always ready
    ifm.m_ready = 1'b1;
    w_en = 1'b1; w_data = 16'd32;
    tick();
    check("A_empty_fell", 32'(ifm.fifo_empty), 32'd0);
    check("A_valid_e0",   32'(ifm.m_valid),    32'd0);
    w_data = 16'd12;
    tick();
    check("A_valid_e1",   32'(ifm.m_valid),    32'd0);
    w_data = 16'd5;
    tick();
    w_en = 1'b0;
    check("A_valid_e2",   32'(ifm.m_valid),    32'd1);
    check("A_data0",      32'(ifm.m_data),     32'd32);
    tick();
    check("A_valid_e3",   32'(ifm.m_valid),    32'd1);
    check("A_data1",      32'(ifm.m_data),     32'd12);
    tick();
    check("A_valid_e4",   32'(ifm.m_valid),    32'd1);
    check("A_data2",      32'(ifm.m_data),     32'd5);
    tick();
    check("A_valid_end",  32'(ifm.m_valid),    32'd0);
    check("A_wcount",     32'(ifm.word_count), 32'd3);
    check("A_wcount4",    32'(if4.word_count), 32'd3);

    // B: eight words with consumer stalled, then released
    ifm.m_ready = 1'b0;
    base = rd_issued;
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; w_data = 16'(100 + i);
      tick();
    end
    w_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("B_hold_valid", 32'(ifm.m_valid), 32'd1);
      check("B_hold_data",  32'(ifm.m_data),  32'd100);
    end
    check("B_reads", 32'(rd_issued - base), 32'd2);
    ifm.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("B_b2b_valid", 32'(ifm.m_valid), 32'd1);
      check("B_b2b_data",  32'(ifm.m_data),  32'(100 + i));
      tick();
    end
    check("B_valid_end", 32'(ifm.m_valid),    32'd0);
    check("B_wcount",    32'(ifm.word_count), 32'd11);

    // C: sixteen words 0..15, consumer toggling every cycle
    ifm.m_ready = 1'b0;
    hs_q.delete();
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; w_data = 16'(i);
      tick();
    end
    w_en = 1'b0;
    for (int k = 0; k < 200 && hs_q.size() < 16; k++) begin
      ifm.m_ready = ~ifm.m_ready;
      tick();
    end
    ifm.m_ready = 1'b0;
    tick();
    check("C_hs_count", 32'(hs_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      obs = (i < hs_q.size()) ? 32'(hs_q[i]) : 32'hFFFF_FFFF;
      check("C_order", obs, 32'(i));
    end
    check("C_valid_end", 32'(ifm.m_valid),    32'd0);
    check("C_wcount",    32'(ifm.word_count), 32'd27);
    check("C_wcount4",   32'(if4.word_count), 32'd11);

    // D: reset mid-stream with a word presented and another in flight
    ifm.m_ready = 1'b1;
    w_en = 1'b1; w_data = 16'd200;
    tick();
    w_data = 16'd201;
    tick();
    w_data = 16'd202;
    tick();
    w_en = 1'b0;
    check("D_pre_valid", 32'(ifm.m_valid), 32'd1);
    check("D_pre_data",  32'(ifm.m_data),  32'd200);
    rst = 1'b1;
    #1;
    check("D_rst_valid",   32'(ifm.m_valid),    32'd0);
    check("D_rst_data",    32'(ifm.m_data),     32'd0);
    check("D_rst_wcount",  32'(ifm.word_count), 32'd0);
    check("D_rst_wcount4", 32'(if4.word_count), 32'd0);
    check("D_rst_r_en",    32'(ifm.fifo_r_en),  32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("D_post_valid", 32'(ifm.m_valid),   32'd0);
      check("D_post_r_en",  32'(ifm.fifo_r_en), 32'd0);
    end

    // E: eighteen words streamed; 4-bit counter wraps to 2
    hs_q.delete();
    ifm.m_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      w_en = 1'b1; w_data = 16'(i + 1000);
      tick();
    end
    w_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("E_hs_count", 32'(hs_q.size()),     32'd18);
    for (int i = 0; i < 18; i++) begin
      obs = (i < hs_q.size()) ? 32'(hs_q[i]) : 32'hFFFF_FFFF;
      check("E_order", obs, 32'(i + 1000));
    end
    check("E_wcount",  32'(ifm.word_count), 32'd18);
    check("E_wcount4", 32'(if4.word_count), 32'd2);
    check("E_valid_end", 32'(ifm.m_valid),  32'd0);

    check("r_en_while_empty", 32'(rd_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
